wb_sequencer: RTL and testbench
===============================

// Module: wb_sequencer
// PURPOSE
//  Writeback controller for the KGPminiRISC datapath; drives the 2-bit select of the MemToReg
//  writeback mux and the register-file write strobe/address. Accepts one writeback request per
//  instruction, waits on variable-latency load data with a timeout, and stalls the front end.
//  Sits between decode/execute and the register file.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles spent in WAIT_MEM before forced zero-writeback (>=2)
//  CNT_W        5   width of the wait counter; must satisfy 2**CNT_W > MEM_TIMEOUT
// PORTS
//  clk            in   1   single clock; all state on posedge
//  rst            in   1   synchronous, active-high reset
//  req_valid      in   1   writeback request present
//  req_ready      out  1   request accepted when req_valid && req_ready
//  req_src        in   2   00 ALU, 01 MEM (load), 10 LINK (PC+4), 11 NONE
//  req_rd         in   5   destination register
//  flush          in   1   abort the pending request (branch/exception)
//  mem_rd_valid   in   1   load data valid this cycle
//  mem_to_reg_sel out  2   mux select: 00 ALU, 01 MEM, 10 LINK, 11 forced zero
//  reg_write      out  1   register-file write enable (1-cycle pulse)
//  reg_waddr      out  5   register-file write address
//  stall          out  1   high while in WAIT_MEM
//  wb_err         out  1   1-cycle pulse when a load timed out
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1; mem_to_reg_sel=00; reg_write=0; reg_waddr=0; stall=0; wb_err=0; counter=0.
//  States: IDLE, WAIT_MEM, WRITE. req_ready = (IDLE||WRITE) && !flush.
//  Accept src 00/10: next cycle state WRITE, reg_write=1, sel=src, reg_waddr=rd (latency 1).
//  Accept src 01: next cycle WAIT_MEM, counter cleared, rd latched; stall=1.
//  Accept src 11: no write; state -> IDLE (no WRITE cycle).
//  WAIT_MEM: counter increments each cycle; mem_rd_valid -> WRITE with sel=01.
//   counter==MEM_TIMEOUT-1 without valid -> WRITE with sel=11, wb_err=1 in that WRITE cycle.
//   mem_rd_valid and timeout in same cycle: valid wins, sel=01, no wb_err.
//  WRITE: outputs held exactly one cycle; new accept here gives back-to-back writes
//   (next state per new src); no accept -> IDLE with reg_write=0.
//  mem_to_reg_sel holds its last value outside WRITE; reg_waddr likewise.
//  flush: WAIT_MEM -> IDLE, no write, no wb_err; flush in WRITE does not cancel that write
//   (already committed) but blocks a new accept; flush in IDLE is a no-op.
//  mem_rd_valid outside WAIT_MEM is ignored.
//  rst mid-operation: immediate return to reset values next edge; pending load is dropped.
//  Counter saturates, never wraps; width CNT_W unsigned.
// STRUCTURE
//  Shared package wb_pkg: WB_SRC_ALU=2'b00, WB_SRC_MEM=2'b01, WB_SRC_LINK=2'b10,
//   WB_SRC_NONE=2'b11, WB_SEL_ZERO=2'b11, state encodings (IDLE/WAIT_MEM/WRITE).
//  One sub-module: wb_timeout_counter (clear, enable, saturating count, hit = count==MEM_TIMEOUT-1).
//  Top: FSM + output registers; selects feed mux_MemToReg directly.
// TESTING
//  ALU req rd=5 -> next cycle reg_write=1, sel=00, waddr=5; following cycle reg_write=0.
//  MEM req rd=7, mem_rd_valid after 3 cycles -> stall=1 for 3 cycles, then WRITE sel=01 waddr=7.
//  MEM req, no valid, MEM_TIMEOUT=16 -> 16 stall cycles, WRITE sel=11, wb_err=1 single pulse.
//  Back-to-back LINK rd=31 then ALU rd=2 -> two consecutive reg_write pulses, sel 10 then 00.
//  MEM req then flush in 2nd wait cycle -> IDLE, no reg_write; late mem_rd_valid ignored.
//  flush with req_valid in IDLE -> req_ready=0, not accepted; rst during WAIT_MEM -> all reset values.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared writeback encodings for the KGPminiRISC writeback path.
package wb_pkg;

    typedef logic [1:0] wb_src_t;

    localparam wb_src_t WB_SRC_ALU  = 2'b00;
    localparam wb_src_t WB_SRC_MEM  = 2'b01;
    localparam wb_src_t WB_SRC_LINK = 2'b10;
    localparam wb_src_t WB_SRC_NONE = 2'b11;
    localparam wb_src_t WB_SEL_ZERO = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_WRITE    = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_timeout_counter.sv
// Saturating wait counter for outstanding loads; hit flags the final allowed wait cycle.
module wb_timeout_counter #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic hit_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign hit_o = (count_q == CNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/wb_sequencer.sv
// Writeback controller: sequences ALU/LINK/load writebacks into the register file and
// drives the MemToReg mux select, stalling the front end while a load is outstanding.
module wb_sequencer
    import wb_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_src,
    input  logic [4:0] req_rd,
    input  logic       flush,
    input  logic       mem_rd_valid,
    output logic [1:0] mem_to_reg_sel,
    output logic       reg_write,
    output logic [4:0] reg_waddr,
    output logic       stall,
    output logic       wb_err
);

    wb_state_e  state_q, state_d;
    wb_src_t    sel_q, sel_d;
    logic [4:0] waddr_q, waddr_d;
    logic [4:0] rd_q, rd_d;
    logic       err_q, err_d;
    logic       cnt_clr, cnt_en, cnt_hit;
    logic       accept;

    wb_timeout_counter #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) u_timeout (
        .clk_i(clk),
        .rst_i(rst),
        .clr_i(cnt_clr),
        .en_i (cnt_en),
        .hit_o(cnt_hit)
    );

    assign req_ready = ((state_q == ST_IDLE) || (state_q == ST_WRITE)) && !flush;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        waddr_d = waddr_q;
        rd_d    = rd_q;
        err_d   = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;

        case (state_q)
            ST_IDLE, ST_WRITE: begin
                state_d = ST_IDLE;
                if (accept) begin
                    case (req_src)
                        WB_SRC_ALU, WB_SRC_LINK: begin
                            state_d = ST_WRITE;
                            sel_d   = req_src;
                            waddr_d = req_rd;
                        end
                        WB_SRC_MEM: begin
                            state_d = ST_WAIT_MEM;
                            rd_d    = req_rd;
                            cnt_clr = 1'b1;
                        end
                        WB_SRC_NONE: state_d = ST_IDLE;
                        default:     state_d = ST_IDLE;
                    endcase
                end
            end
            ST_WAIT_MEM: begin
                cnt_en = 1'b1;
                // Flush beats late data and timeout; valid data beats timeout.
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (mem_rd_valid) begin
                    state_d = ST_WRITE;
                    sel_d   = WB_SRC_MEM;
                    waddr_d = rd_q;
                end else if (cnt_hit) begin
                    state_d = ST_WRITE;
                    sel_d   = WB_SEL_ZERO;
                    waddr_d = rd_q;
                    err_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            waddr_q <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            waddr_q <= waddr_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    assign mem_to_reg_sel = sel_q;
    assign reg_waddr      = waddr_q;
    assign reg_write      = (state_q == ST_WRITE);
    assign stall          = (state_q == ST_WAIT_MEM);
    assign wb_err         = err_q;

endmodule

// File: tb/tb_wb_sequencer.sv
// Bench for wb_sequencer: directed vector table, timeout corner sequences, and random
// stimulus checked against a transaction-level model of the writeback rules.
module tb_wb_sequencer;

    localparam int TO = 16;

    typedef struct packed {
        logic       rst;
        logic       vld;
        logic [1:0] src;
        logic [4:0] rd;
        logic       fl;
        logic       mv;
    } in_t;

    typedef struct packed {
        logic       rdy;
        logic       wr;
        logic [1:0] sel;
        logic [4:0] waddr;
        logic       stall;
        logic       err;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, req_valid, flush, mem_rd_valid;
    logic [1:0] req_src;
    logic [4:0] req_rd;
    logic       req_ready, reg_write, stall, wb_err;
    logic [1:0] mem_to_reg_sel;
    logic [4:0] reg_waddr;

    int n_vec = 0;
    int n_err = 0;

    // Model: a load is either outstanding (with cycles waited so far) or not; the write
    // strobe/select/address describe what the register file sees this cycle.
    bit         m_busy, m_wr, m_err;
    logic [1:0] m_sel;
    logic [4:0] m_waddr, m_rd;
    int         m_waited;

    always #5 clk = ~clk;

    wb_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_src       (req_src),
        .req_rd        (req_rd),
        .flush         (flush),
        .mem_rd_valid  (mem_rd_valid),
        .mem_to_reg_sel(mem_to_reg_sel),
        .reg_write     (reg_write),
        .reg_waddr     (reg_waddr),
        .stall         (stall),
        .wb_err        (wb_err)
    );

    task automatic model_step();
        if (rst) begin
            m_busy = 0; m_wr = 0; m_err = 0; m_sel = 2'b00; m_waddr = '0; m_rd = '0; m_waited = 0;
        end else if (m_busy) begin
            m_wr = 0; m_err = 0;
            if (flush) begin
                m_busy = 0;
            end else if (mem_rd_valid) begin
                m_busy = 0; m_wr = 1; m_sel = 2'b01; m_waddr = m_rd;
            end else if (m_waited + 1 == TO) begin
                m_busy = 0; m_wr = 1; m_sel = 2'b11; m_waddr = m_rd; m_err = 1;
            end else begin
                m_waited++;
            end
        end else begin
            m_wr = 0; m_err = 0;
            if (req_valid && !flush) begin
                if (req_src == 2'b00 || req_src == 2'b10) begin
                    m_wr = 1; m_sel = req_src; m_waddr = req_rd;
                end else if (req_src == 2'b01) begin
                    m_busy = 1; m_waited = 0; m_rd = req_rd;
                end
            end
        end
    endtask

    function automatic out_t model_out();
        out_t o;
        o.rdy   = !m_busy && !flush;
        o.wr    = m_wr;
        o.sel   = m_sel;
        o.waddr = m_waddr;
        o.stall = m_busy;
        o.err   = m_err;
        return o;
    endfunction

    function automatic vec_t mk(input logic r, vl, input logic [1:0] s, input logic [4:0] d,
                                input logic f, m, input logic rdy, wr, input logic [1:0] sel,
                                input logic [4:0] wa, input logic st, er);
        vec_t v;
        v.i = '{rst: r, vld: vl, src: s, rd: d, fl: f, mv: m};
        v.o = '{rdy: rdy, wr: wr, sel: sel, waddr: wa, stall: st, err: er};
        return v;
    endfunction

    task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input out_t e);
        cmp({tag, ".req_ready"}, 8'(req_ready), 8'(e.rdy));
        cmp({tag, ".reg_write"}, 8'(reg_write), 8'(e.wr));
        cmp({tag, ".sel"},       8'(mem_to_reg_sel), 8'(e.sel));
        cmp({tag, ".waddr"},     8'(reg_waddr), 8'(e.waddr));
        cmp({tag, ".stall"},     8'(stall), 8'(e.stall));
        cmp({tag, ".wb_err"},    8'(wb_err), 8'(e.err));
    endtask

    task automatic set_in(input in_t x);
        rst = x.rst; req_valid = x.vld; req_src = x.src; req_rd = x.rd;
        flush = x.fl; mem_rd_valid = x.mv;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic run_model(input string tag, input in_t x);
        set_in(x);
        #1 check_outs(tag, model_out());
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[28];
        in_t  idle, x;
        int   stalls;
        bit   done;

        idle = '{rst: 0, vld: 0, src: 2'b00, rd: 5'd0, fl: 0, mv: 0};

        //            rst vld src    rd     fl mv   rdy wr sel    waddr  st er
        tbl[0]  = mk(0, 0, 2'b00, 5'd0,  0, 0,  1, 0, 2'b00, 5'd0,  0, 0);
        tbl[1]  = mk(0, 1, 2'b00, 5'd5,  0, 0,  1, 0, 2'b00, 5'd0,  0, 0);
        tbl[2]  = mk(0, 0, 2'b00, 5'd0,  0, 0,  1, 1, 2'b00, 5'd5,  0, 0);
        tbl[3]  = mk(0, 1, 2'b10, 5'd31, 0, 0,  1, 0, 2'b00, 5'd5,  0, 0);
        tbl[4]  = mk(0, 1, 2'b00, 5'd2,  0, 0,  1, 1, 2'b10, 5'd31, 0, 0);
        tbl[5]  = mk(0, 0, 2'b00, 5'd0,  0, 0,  1, 1, 2'b00, 5'd2,  0, 0);
        tbl[6]  = mk(0, 1, 2'b11, 5'd9,  0, 0,  1, 0, 2'b00, 5'd2,  0, 0);
        tbl[7]  = mk(0, 0, 2'b00, 5'd0,  0, 1,  1, 0, 2'b00, 5'd2,  0, 0);
        tbl[8]  = mk(0, 1, 2'b00, 5'd3,  1, 0,  0, 0, 2'b00, 5'd2,  0, 0);
        tbl[9]  = mk(0, 1, 2'b01, 5'd7,  0, 0,  1, 0, 2'b00, 5'd2,  0, 0);
        tbl[10] = mk(0, 0, 2'b00, 5'd0,  0, 0,  0, 0, 2'b00, 5'd2,  1, 0);
        tbl[11] = mk(0, 0, 2'b00, 5'd0,  0, 0,  0, 0, 2'b00, 5'd2,  1, 0);
        tbl[12] = mk(0, 0, 2'b00, 5'd0,  0, 1,  0, 0, 2'b00, 5'd2,  1, 0);
        tbl[13] = mk(0, 1, 2'b00, 5'd4,  1, 0,  0, 1, 2'b01, 5'd7,  0, 0);
        tbl[14] = mk(0, 0, 2'b00, 5'd0,  0, 0,  1, 0, 2'b01, 5'd7,  0, 0);
        tbl[15] = mk(0, 1, 2'b01, 5'd12, 0, 0,  1, 0, 2'b01, 5'd7,  0, 0);
        tbl[16] = mk(0, 0, 2'b00, 5'd0,  0, 0,  0, 0, 2'b01, 5'd7,  1, 0);
        tbl[17] = mk(0, 1, 2'b00, 5'd6,  1, 0,  0, 0, 2'b01, 5'd7,  1, 0);
        tbl[18] = mk(0, 0, 2'b00, 5'd0,  0, 1,  1, 0, 2'b01, 5'd7,  0, 0);
        tbl[19] = mk(0, 0, 2'b00, 5'd0,  0, 0,  1, 0, 2'b01, 5'd7,  0, 0);
        tbl[20] = mk(0, 1, 2'b01, 5'd20, 0, 0,  1, 0, 2'b01, 5'd7,  0, 0);
        tbl[21] = mk(1, 0, 2'b00, 5'd0,  0, 0,  0, 0, 2'b01, 5'd7,  1, 0);
        tbl[22] = mk(0, 0, 2'b00, 5'd0,  0, 0,  1, 0, 2'b00, 5'd0,  0, 0);
        tbl[23] = mk(0, 1, 2'b00, 5'd1,  0, 0,  1, 0, 2'b00, 5'd0,  0, 0);
        tbl[24] = mk(0, 1, 2'b01, 5'd8,  0, 0,  1, 1, 2'b00, 5'd1,  0, 0);
        tbl[25] = mk(0, 0, 2'b00, 5'd0,  0, 1,  0, 0, 2'b00, 5'd1,  1, 0);
        tbl[26] = mk(0, 0, 2'b00, 5'd0,  0, 0,  1, 1, 2'b01, 5'd8,  0, 0);
        tbl[27] = mk(0, 0, 2'b00, 5'd0,  0, 0,  1, 0, 2'b01, 5'd8,  0, 0);

        x = idle;
        x.rst = 1;
        set_in(x);
        tick();
        tick();

        for (int i = 0; i < 28; i++) begin
            set_in(tbl[i].i);
            #1 check_outs($sformatf("tbl%0d", i), tbl[i].o);
            tick();
        end

        // Load that never returns: full wait window, then forced-zero write with error pulse.
        x = '{rst: 0, vld: 1, src: 2'b01, rd: 5'd14, fl: 0, mv: 0};
        run_model("to_acc", x);
        stalls = 0;
        done   = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            set_in(idle);
            #1 check_outs("to_wait", model_out());
            if (stall) stalls++;
            if (reg_write) begin
                done = 1;
                cmp("to_sel",   8'(mem_to_reg_sel), 8'h03);
                cmp("to_err",   8'(wb_err),         8'h01);
                cmp("to_waddr", 8'(reg_waddr),      8'd14);
            end
            tick();
        end
        cmp("to_write_seen",   8'(done),   8'h01);
        cmp("to_stall_cycles", 8'(stalls), 8'(TO));
        set_in(idle);
        #1 cmp("to_err_pulse_end", 8'(wb_err), 8'h00);
        tick();

        // Data arriving in the last allowed wait cycle wins over the timeout.
        x = '{rst: 0, vld: 1, src: 2'b01, rd: 5'd15, fl: 0, mv: 0};
        run_model("vt_acc", x);
        for (int k = 0; k < TO - 1; k++) run_model("vt_wait", idle);
        x = idle;
        x.mv = 1;
        run_model("vt_last", x);
        set_in(idle);
        #1;
        cmp("vt_write", 8'(reg_write),      8'h01);
        cmp("vt_sel",   8'(mem_to_reg_sel), 8'h01);
        cmp("vt_err",   8'(wb_err),         8'h00);
        cmp("vt_waddr", 8'(reg_waddr),      8'd15);
        tick();

        for (int n = 0; n < 2000; n++) begin
            x.rst = ($urandom_range(99) == 0);
            x.vld = 1'($urandom_range(1));
            x.src = 2'($urandom_range(3));
            x.rd  = 5'($urandom_range(31));
            x.fl  = ($urandom_range(15) == 0);
            x.mv  = ($urandom_range(7) == 0);
            run_model("rnd", x);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
